// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from instruction memory
// over a req/ack handshake, and holds the fetched word for decode. The low
// twelve bits of the held word feed the immediate sign extender directly.
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       instr,
    output logic [11:0]       imm12,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    // REQ: a fetch is outstanding at pc_q. VALID: instr_q holds a word for decode.
    typedef enum logic {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [31:0]       instr_q, instr_d;
    logic              kill_q, kill_d;

    // State register with asynchronous reset so outputs drop as soon as reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            kill_q   <= kill_d;
        end
    end

    // Next-state logic. A redirect during an unacknowledged fetch cannot withdraw
    // the request, so it is remembered (kill + pending target) and the stale word
    // is dropped when it finally arrives.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        kill_d   = kill_q;

        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Redirect coinciding with the data: the word is for the
                        // old path, so drop it and refetch at the target.
                        pc_d   = branch_target;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        // Stale word from before the redirect.
                        pc_d   = pend_q;
                        kill_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + STEP;
                        state_d  = S_VALID;
                    end
                end else if (branch_taken) begin
                    // Address must stay put until the ack; a later redirect
                    // simply replaces the remembered target.
                    kill_d = 1'b1;
                    pend_d = branch_target;
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Output decode; the request is masked while reset is held.
    always_comb begin
        imem_req    = (state_q == S_REQ) && !reset;
        imem_addr   = pc_q;
        instr_valid = (state_q == S_VALID);
        instr       = instr_q;
        imm12       = instr_q[11:0];
        pc_out      = pc_out_q;
    end

endmodule
